// File: rtl/alu_stream_if.sv
// Command and result handshake bundle for alu_stream_unit.
interface alu_stream_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] data_out;
   logic [2:0]       data_type;
   logic [3:0]       flags;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, data_out, data_type, flags, out_valid
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, data_out, data_type, flags, out_valid
   );
endinterface

// File: rtl/alu_stream_unit.sv
// Streaming ALU: one registered compute stage feeding a show-ahead result FIFO.
module alu_stream_unit #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int SATURATE = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_stream_if.slave      bus,
   output logic [CNT_W-1:0] result_count
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [2:0]       op;
      logic [3:0]       flags;
   } entry_t;

   logic [WIDTH-1:0] a, b, res;
   logic [WIDTH:0]   add_x, sub_x;
   logic             c, v;
   entry_t           alu_e;

   assign a     = bus.in_a;
   assign b     = bus.in_b;
   assign add_x = {1'b0, a} + {1'b0, b};
   assign sub_x = {1'b0, a} - {1'b0, b};

   always_comb begin
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (bus.in_op)
         3'd0: begin
            res = add_x[WIDTH-1:0];
            c   = add_x[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         3'd1: begin
            res = sub_x[WIDTH-1:0];
            c   = sub_x[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: res = ~a;
         3'd6: begin
            res = {a[WIDTH-2:0], 1'b0};
            c   = a[WIDTH-1];
         end
         default: begin
            res = {a[WIDTH-1], a[WIDTH-1:1]};
            c   = a[0];
         end
      endcase
      // Overflow direction follows the sign of a for both ADD and SUB.
      if (SATURATE != 0 && v)
         res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      alu_e.res   = res;
      alu_e.op    = bus.in_op;
      alu_e.flags = {res == '0, res[WIDTH-1], c, v};
   end

   logic            stage_vld_q, stage_vld_d;
   entry_t          stage_q, stage_d;
   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
   logic [AW+1:0]   occ;
   logic            accept, push, pop, out_vld;
   entry_t          head;

   // The stage entry already holds a slot, so occupancy counts it.
   assign occ          = {1'b0, cnt_q} + {{(AW+1){1'b0}}, stage_vld_q};
   assign bus.in_ready = occ < (AW+2)'(DEPTH);
   assign accept       = bus.in_valid && bus.in_ready && !rst;
   assign out_vld      = cnt_q != '0;
   assign push         = stage_vld_q;
   assign pop          = out_vld && bus.out_ready;

   always_comb begin
      stage_vld_d = accept;
      stage_d     = alu_e;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      res_cnt_d   = pop  ? res_cnt_q + 1'b1 : res_cnt_q;
      cnt_d       = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push && pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_vld_q <= 1'b0;
         stage_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         res_cnt_q   <= '0;
      end else begin
         stage_vld_q <= stage_vld_d;
         stage_q     <= stage_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= stage_q;
   end

   assign head          = mem_q[rd_ptr_q];
   assign bus.out_valid = out_vld;
   assign bus.data_out  = out_vld ? head.res   : '0;
   assign bus.data_type = out_vld ? head.op    : '0;
   assign bus.flags     = out_vld ? head.flags : '0;
   assign result_count  = res_cnt_q;
endmodule

// File: tb/tb_alu_stream_unit.sv
// Scoreboard bench: wrapping and saturating instances driven with identical stimulus.
module tb_alu_stream_unit;
   typedef struct packed {
      logic [7:0] res;
      logic [2:0] typ;
      logic [3:0] fl;
   } exp_t;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      exp_t       w;
      exp_t       s;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cnt0, cnt1;
   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        q0[$], q1[$];
   exp_t        m0, m1;
   vec_t        tbl[14];

   alu_stream_if #(.WIDTH(8)) b0();
   alu_stream_if #(.WIDTH(8)) b1();

   alu_stream_unit #(.WIDTH(8), .DEPTH(4), .SATURATE(0), .CNT_W(16)) u_wrap (
      .clk(clk), .rst(rst), .bus(b0), .result_count(cnt0));
   alu_stream_unit #(.WIDTH(8), .DEPTH(4), .SATURATE(1), .CNT_W(16)) u_sat (
      .clk(clk), .rst(rst), .bus(b1), .result_count(cnt1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input bit sat);
      int   sa, sb, ua, ub, r;
      bit   c, v;
      exp_t e;
      sa = $signed(a); sb = $signed(b); ua = a; ub = b;
      c = 0; v = 0; r = 0;
      case (op)
         3'd0: begin r = sa + sb; c = (ua + ub) > 255; end
         3'd1: begin r = sa - sb; c = ua < ub; end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
         default: begin r = {a[7], a[7:1]}; c = a[0]; end
      endcase
      if (op <= 3'd1) begin
         v = (r > 127) || (r < -128);
         if (v && sat) r = (r > 127) ? 127 : -128;
      end
      e.res = r[7:0];
      e.typ = op;
      e.fl  = {e.res == 8'd0, e.res[7], c, v};
      return e;
   endfunction

   task automatic set_ordy(input logic v);
      b0.out_ready = v;
      b1.out_ready = v;
   endtask

   task automatic present(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      b0.in_valid = 1'b1; b0.in_op = op; b0.in_a = a; b0.in_b = b;
      b1.in_valid = 1'b1; b1.in_op = op; b1.in_a = a; b1.in_b = b;
   endtask

   task automatic idle();
      b0.in_valid = 1'b0;
      b1.in_valid = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e0, input exp_t e1);
      int n = 0;
      present(op, a, b);
      while (!b0.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("accept timeout", b0.in_ready, 1);
      end else begin
         q0.push_back(e0);
         q1.push_back(e1);
         @(negedge clk);
      end
      idle();
   endtask

   task automatic send_m(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      send(op, a, b, model(op, a, b, 0), model(op, a, b, 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain pending", q0.size() + q1.size(), 0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   always @(negedge clk) begin
      #2;
      if (b0.out_valid && b0.out_ready) begin
         if (q0.size() == 0) chk("spurious wrap out", b0.out_valid, 0);
         else begin
            m0 = q0.pop_front();
            chk("wrap out", {b0.data_out, b0.data_type, b0.flags}, m0);
         end
      end
      if (b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) chk("spurious sat out", b1.out_valid, 0);
         else begin
            m1 = q1.pop_front();
            chk("sat out", {b1.data_out, b1.data_type, b1.flags}, m1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{3'd0, 8'd100, 8'd27,  '{8'd127, 3'd0, 4'b0000}, '{8'd127, 3'd0, 4'b0000}};
      tbl[1]  = '{3'd0, 8'd100, 8'd28,  '{8'h80,  3'd0, 4'b0101}, '{8'd127, 3'd0, 4'b0001}};
      tbl[2]  = '{3'd0, 8'h9C,  8'hE3,  '{8'h7F,  3'd0, 4'b0011}, '{8'h80,  3'd0, 4'b0111}};
      tbl[3]  = '{3'd1, 8'd5,   8'd5,   '{8'h00,  3'd1, 4'b1000}, '{8'h00,  3'd1, 4'b1000}};
      tbl[4]  = '{3'd1, 8'd3,   8'd5,   '{8'hFE,  3'd1, 4'b0110}, '{8'hFE,  3'd1, 4'b0110}};
      tbl[5]  = '{3'd6, 8'h81,  8'h00,  '{8'h02,  3'd6, 4'b0010}, '{8'h02,  3'd6, 4'b0010}};
      tbl[6]  = '{3'd7, 8'h80,  8'h00,  '{8'hC0,  3'd7, 4'b0100}, '{8'hC0,  3'd7, 4'b0100}};
      tbl[7]  = '{3'd2, 8'hF0,  8'h3C,  '{8'h30,  3'd2, 4'b0000}, '{8'h30,  3'd2, 4'b0000}};
      tbl[8]  = '{3'd3, 8'hF0,  8'h0C,  '{8'hFC,  3'd3, 4'b0100}, '{8'hFC,  3'd3, 4'b0100}};
      tbl[9]  = '{3'd4, 8'h55,  8'h55,  '{8'h00,  3'd4, 4'b1000}, '{8'h00,  3'd4, 4'b1000}};
      tbl[10] = '{3'd5, 8'h00,  8'h12,  '{8'hFF,  3'd5, 4'b0100}, '{8'hFF,  3'd5, 4'b0100}};
      tbl[11] = '{3'd1, 8'h80,  8'h01,  '{8'h7F,  3'd1, 4'b0001}, '{8'h80,  3'd1, 4'b0101}};
      tbl[12] = '{3'd7, 8'h03,  8'h00,  '{8'h01,  3'd7, 4'b0010}, '{8'h01,  3'd7, 4'b0010}};
      tbl[13] = '{3'd0, 8'hFF,  8'h01,  '{8'h00,  3'd0, 4'b1010}, '{8'h00,  3'd0, 4'b1010}};

      rst = 1'b1;
      idle();
      present(3'd0, 8'd0, 8'd0);
      idle();
      set_ordy(1'b0);
      repeat (2) @(negedge clk);
      chk("reset out_valid", b0.out_valid, 0);
      chk("reset in_ready", b0.in_ready, 1);
      chk("reset head", {b0.data_out, b0.data_type, b0.flags}, 0);
      chk("reset count", cnt0, 0);
      rst = 1'b0;

      // Table vectors, back to back with the consumer always ready
      set_ordy(1'b1);
      foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].s);
      drain();
      chk("table count wrap", cnt0, 14);
      chk("table count sat", cnt1, 14);

      // Backpressure: only DEPTH commands fit while the consumer stalls
      pulse_rst();
      set_ordy(1'b0);
      for (int i = 1; i <= 4; i++) send_m(3'd0, 8'(i), 8'd0);
      present(3'd0, 8'd5, 8'd0);
      repeat (3) begin
         @(negedge clk);
         chk("bp in_ready", b0.in_ready, 0);
      end
      chk("bp head", b0.data_out, 1);
      chk("bp out_valid", b0.out_valid, 1);
      set_ordy(1'b1);
      send_m(3'd0, 8'd5, 8'd0);
      send_m(3'd0, 8'd6, 8'd0);
      drain();
      chk("bp result_count", cnt0, 6);
      chk("bp result_count sat", cnt1, 6);

      // Full FIFO with simultaneous push and pop
      set_ordy(1'b0);
      for (int i = 0; i < 4; i++) send_m(3'(i), 8'($urandom), 8'($urandom));
      @(negedge clk);
      chk("full in_ready", b0.in_ready, 0);
      set_ordy(1'b1);
      fork
         begin
            for (int i = 0; i < 10; i++) send_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         end
         begin
            repeat (10) begin
               @(negedge clk);
               chk("full out_valid", b0.out_valid, 1);
            end
         end
      join
      drain();
      chk("full result_count", cnt0, 20);

      // Reset with three buffered results and one in the stage
      set_ordy(1'b0);
      for (int i = 0; i < 4; i++) send_m(3'd0, 8'(10 + i), 8'd1);
      chk("pre-rst out_valid", b0.out_valid, 1);
      rst = 1'b1;
      present(3'd0, 8'd9, 8'd9);
      @(negedge clk);
      rst = 1'b0;
      idle();
      q0.delete();
      q1.delete();
      chk("rst out_valid", b0.out_valid, 0);
      chk("rst data_out", b0.data_out, 0);
      chk("rst in_ready", b0.in_ready, 1);
      chk("rst count", cnt0, 0);
      repeat (2) begin
         @(negedge clk);
         chk("rst stays empty", b0.out_valid, 0);
      end
      set_ordy(1'b1);
      send(3'd0, 8'd1, 8'd1, '{8'd2, 3'd0, 4'b0000}, '{8'd2, 3'd0, 4'b0000});
      drain();
      chk("post-rst count", cnt0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
